sync_read_mem_lanes: RTL
========================

// Module: sync_read_mem_lanes
// PURPOSE
//  Parametrised single-write / single-read synchronous memory for generated designs.
//  Adds per-lane write masks, a selectable read-during-write policy, and an optional second output register.
//  Adds an rvalid qualifier and async-reset read-side state.
//  Drop-in successor for ROM/RAM instances: init image is loaded at elaboration; reset never touches the array.
// PARAMETERS
//  WIDTH     5     data width in bits
//  DEPTH     4     number of words; any value >= 2, need not be a power of two
//  LANE_W    WIDTH write-lane width; WIDTH % LANE_W == 0; NLANES = WIDTH/LANE_W
//  HAS_INIT  0     1 = load INIT into array at time zero
//  INIT      0     [WIDTH*DEPTH-1:0] image; word j = INIT[(j+1)*WIDTH-1 : j*WIDTH]
//  RDW_MODE  0     read-during-write same address: 0 = OLD data, 1 = NEW (forwarded, lane-merged)
//  OUT_REG   0     0 = read latency 1; 1 = read latency 2 (extra output register)
// PORTS
//  clk     in   1              rising-edge clock
//  arst_n  in   1              asynchronous active-low reset
//  wen     in   1              write enable
//  waddr   in   AW=$clog2(DEPTH)  write address
//  wdata   in   WIDTH          write data
//  wmask   in   NLANES         per-lane write enable; lane i = bits [(i+1)*LANE_W-1 : i*LANE_W]
//  ren     in   1              read enable
//  raddr   in   AW             read address
//  rdata   out  WIDTH          read data, holds last value when no new read completes
//  rvalid  out  1              1-cycle pulse: rdata updated this cycle by a completed read
// BEHAVIOUR
//  - Reset (arst_n=0, async assert, sync deassert by integration): rdata=0, rvalid=0, output-stage regs=0.
//    The array is NOT cleared; it keeps contents, or INIT if no write has occurred.
//  - Write: at posedge with wen=1 and waddr<DEPTH, lanes with wmask[i]=1 are updated; other lanes keep their values.
//    A write with wmask all-zero is a no-op. A write with waddr>=DEPTH is dropped silently.
//  - Writes are honoured during reset; the array is not reset-gated.
//  - Read: ren=1 at edge N samples raddr.
//    OUT_REG=0: rdata/rvalid valid after edge N (latency 1). OUT_REG=1: after edge N+1 (latency 2).
//    ren=0: rdata holds, rvalid=0. raddr>=DEPTH: rdata=0, rvalid=1.
//  - Read-during-write, same address, same edge:
//    RDW_MODE=0 -> pre-write word. RDW_MODE=1 -> per lane, wdata where wmask=1, old word elsewhere.
//    Different addresses: no interaction.
//  - Back-to-back reads every cycle are supported: throughput 1/cycle in both OUT_REG modes.
//  - Reset asserted mid-read: in-flight results are discarded (rvalid stays 0 until a new ren after reset release).
// STRUCTURE
//  - Package sync_mem_pkg holds the constants and the helper:
//    RDW_OLD=0, RDW_NEW=1; function lane_merge(old, new, mask, LANE_W) shared with the forwarding path.
//  - Top: array, write logic, read stage 1 (data + valid).
//  - Sub-module sync_mem_out_stage (WIDTH): optional second register for data + valid with async reset.
//    Generated only when OUT_REG=1; otherwise stage 1 drives the ports directly.
//  - Elaboration-time checks: WIDTH%LANE_W==0, DEPTH>=2, RDW_MODE in {0,1}, OUT_REG in {0,1}.
// TESTING
//  1. WIDTH=5, DEPTH=4, HAS_INIT=1, INIT={11,21,0,5}; ren=1, raddr=0..3 on consecutive cycles
//     -> rdata=5,0,21,11 one cycle later each, rvalid=1 each cycle.
//  2. WIDTH=16, LANE_W=8: write 0xABCD to addr 2, then wmask=2'b10 with wdata 0x1200
//     -> read addr 2 returns 0x12CD.
//  3. Same edge: wen=1, ren=1, addr 1, old=0x0000, wdata=0xFFFF, wmask=2'b01
//     -> RDW_MODE=0 returns 0x0000; RDW_MODE=1 returns 0x00FF.
//  4. OUT_REG=1: ren pulse at edge N -> rvalid high only after edge N+1; a 4-read burst gives 4 contiguous rvalid cycles.
//  5. DEPTH=5: write addr 7 -> array unchanged; read addr 6 -> rdata=0, rvalid=1.
//  6. Reset mid-operation: ren=1 at edge N, arst_n low before edge N+1
//     -> rdata=0 and rvalid=0 immediately and after release; the array still holds the prior writes on re-read.

Source files
------------

// File: rtl/sync_mem_pkg.sv
// Shared constants and the lane-merge helper for the lane-masked synchronous memory.
// The same merge serves the array write path and the read-during-write forwarding path.
package sync_mem_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers zero-extend in and truncate out.
    localparam int MAX_W = 256;

    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_W-1:0] mask,
        input int               lane_w
    );
        logic [MAX_W-1:0] res;
        int               lane_idx;
        res      = old_w;
        lane_idx = 0;
        for (int b = 0; b < MAX_W; b++) begin
            if (lane_w > 0) begin
                lane_idx = b / lane_w;
            end else begin
                lane_idx = 0;
            end
            if (mask[lane_idx[7:0]]) begin
                res[b] = new_w[b];
            end else begin
                res[b] = old_w[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_mem_out_stage.sv
// Optional second output register for read data and its valid qualifier.
// Data holds unless a valid result arrives; async reset clears both.
module sync_mem_out_stage #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;

    // Capture data only when a completed read passes through.
    always_comb begin
        data_d = data_q;
        if (valid_i) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Output register with async reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/sync_read_mem_lanes.sv
// Single-write / single-read synchronous memory with per-lane write masks,
// selectable read-during-write policy and an optional extra output register.
module sync_read_mem_lanes
    import sync_mem_pkg::*;
#(
    parameter int                     WIDTH    = 5,
    parameter int                     DEPTH    = 4,
    parameter int                     LANE_W   = WIDTH,
    parameter int                     HAS_INIT = 0,
    parameter logic [WIDTH*DEPTH-1:0] INIT     = '0,
    parameter int                     RDW_MODE = 0,
    parameter int                     OUT_REG  = 0,
    localparam int                    NLANES   = WIDTH / LANE_W,
    localparam int                    AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [NLANES-1:0] wmask,
    input  logic              ren,
    input  logic [AW-1:0]     raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid
);

    if (LANE_W < 1 || (WIDTH % LANE_W) != 0) begin : g_chk_lane
        $fatal(1, "sync_read_mem_lanes: WIDTH must be a multiple of LANE_W");
    end
    if (DEPTH < 2) begin : g_chk_depth
        $fatal(1, "sync_read_mem_lanes: DEPTH must be at least 2");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_chk_rdw
        $fatal(1, "sync_read_mem_lanes: RDW_MODE must be 0 or 1");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_chk_outreg
        $fatal(1, "sync_read_mem_lanes: OUT_REG must be 0 or 1");
    end
    if (WIDTH > MAX_W) begin : g_chk_width
        $fatal(1, "sync_read_mem_lanes: WIDTH exceeds lane_merge capacity");
    end

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Array is loaded at elaboration and never touched by reset.
    logic [DEPTH-1:0][WIDTH-1:0] mem_q = (HAS_INIT != 0) ? INIT : '0;

    logic             waddr_ok_s;
    logic             raddr_ok_s;
    logic             wr_en_s;
    logic             fwd_s;
    logic [WIDTH-1:0] wr_old_s;
    logic [WIDTH-1:0] wr_word_s;
    logic [WIDTH-1:0] rd_word_s;
    logic [WIDTH-1:0] rd_next_s;
    logic [WIDTH-1:0] rdata1_q;
    logic [WIDTH-1:0] rdata1_d;
    logic             rvalid1_q;

    assign waddr_ok_s = ({1'b0, waddr} < DEPTH_C);
    assign raddr_ok_s = ({1'b0, raddr} < DEPTH_C);
    assign wr_en_s    = wen && waddr_ok_s;
    assign fwd_s      = (RDW_MODE == RDW_NEW) && wr_en_s && raddr_ok_s && (waddr == raddr);

    // Fetch the word under write; an all-zero mask merges back to itself.
    always_comb begin
        wr_old_s = '0;
        if (waddr_ok_s) begin
            wr_old_s = mem_q[waddr];
        end else begin
            wr_old_s = '0;
        end
        wr_word_s = WIDTH'(lane_merge(MAX_W'(wr_old_s), MAX_W'(wdata), MAX_W'(wmask), LANE_W));
    end

    // Read mux: out-of-range reads return zero, same-address NEW mode forwards the merged word.
    always_comb begin
        rd_word_s = '0;
        rd_next_s = '0;
        if (raddr_ok_s) begin
            rd_word_s = mem_q[raddr];
        end else begin
            rd_word_s = '0;
        end
        if (fwd_s) begin
            rd_next_s = wr_word_s;
        end else begin
            rd_next_s = rd_word_s;
        end
    end

    // Array write port, deliberately outside reset so writes land even while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[waddr] <= wr_word_s;
        end
    end

    // Stage-1 data holds its value when no read is requested.
    always_comb begin
        rdata1_d = rdata1_q;
        if (ren) begin
            rdata1_d = rd_next_s;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // Stage-1 read register with async reset discarding in-flight results.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rdata1_q  <= rdata1_d;
            rvalid1_q <= ren;
        end
    end

    if (OUT_REG == 1) begin : g_out_reg
        sync_mem_out_stage #(
            .WIDTH(WIDTH)
        ) u_out_stage (
            .clk    (clk),
            .arst_n (arst_n),
            .data_i (rdata1_q),
            .valid_i(rvalid1_q),
            .data_o (rdata),
            .valid_o(rvalid)
        );
    end else begin : g_no_out_reg
        assign rdata  = rdata1_q;
        assign rvalid = rvalid1_q;
    end

endmodule
